// File: rtl/dataflow_ctrl_pkg.sv
// Shared types and helpers for the dataflow region start/ready/done sequencer.
// Imported by the sequencer top and its watchdog.
package dataflow_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int WD_W_DEF        = 16;
  localparam int STALL_LIMIT_DEF = 1000;
  localparam int MAX_PROC        = 32;

  function automatic logic all_set(
    input logic [MAX_PROC-1:0] vec,
    input int                  n
  );
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_PROC; i++) begin
      if (i < n) r = r & vec[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dataflow_start_ctrl_watchdog.sv
// Stall watchdog: no-progress counter, trip compare and origin capture.
// The origin vector names processes started but never readied.
module dataflow_watchdog
  import dataflow_ctrl_pkg::*;
#(
  parameter int NUM_PROC    = 2,
  parameter int WD_W        = WD_W_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                hold,
  input  logic                clr,
  input  logic                stall_clr,
  input  logic                progress,
  input  logic [NUM_PROC-1:0] rdy_seen,
  input  logic [NUM_PROC-1:0] rdy_ev,
  output logic                trip,
  output logic                stall_flag,
  output logic [NUM_PROC-1:0] stall_origin
);

  localparam logic [WD_W-1:0] LIMIT  = WD_W'(STALL_LIMIT - 1);
  localparam logic [WD_W-1:0] WD_MAX = '1;

  logic [WD_W-1:0] wd_cnt;

  assign trip = run & ~progress & (wd_cnt == LIMIT);

  // No-progress counter: zero in IDLE, saturating while running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (hold | clr) begin
      wd_cnt <= '0;
    end else if (run) begin
      if (progress)
        wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Sticky trip flag and snapshot of the unreadied processes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_flag   <= 1'b0;
      stall_origin <= '0;
    end else if (trip) begin
      stall_flag   <= 1'b1;
      stall_origin <= ~rdy_seen & ~rdy_ev;
    end else if (stall_clr) begin
      stall_flag   <= 1'b0;
      stall_origin <= '0;
    end
  end

endmodule

// File: rtl/dataflow_start_ctrl.sv
// Start/ready/done sequencer for a task-level dataflow region.
// Fans ap_start out per process and joins ready/done back.
module dataflow_start_ctrl
  import dataflow_ctrl_pkg::*;
#(
  parameter int NUM_PROC    = 2,
  parameter int WD_W        = WD_W_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic                ap_done,
  output logic                ap_idle,
  output logic [NUM_PROC-1:0] proc_start,
  input  logic [NUM_PROC-1:0] proc_ready,
  input  logic [NUM_PROC-1:0] proc_done,
  input  logic [NUM_PROC-1:0] proc_idle,
  output logic [NUM_PROC-1:0] proc_ready_seen,
  input  logic                stall_clr,
  output logic                stall_flag,
  output logic [NUM_PROC-1:0] stall_origin
);

  state_t              state;
  state_t              state_nxt;
  logic [NUM_PROC-1:0] rdy_seen;
  logic [NUM_PROC-1:0] done_seen;
  logic [NUM_PROC-1:0] rdy_ev;
  logic                progress;
  logic                trip;
  logic                st_clr;

  assign proc_start = {NUM_PROC{ap_start & ~stall_flag}} & ~rdy_seen;
  assign rdy_ev     = proc_start & proc_ready;

  assign ap_ready = ~reset & ap_start
                  & all_set(MAX_PROC'(rdy_seen | rdy_ev), NUM_PROC);
  assign ap_done  = ~reset
                  & all_set(MAX_PROC'(done_seen | proc_done), NUM_PROC);
  assign ap_idle  = all_set(MAX_PROC'(proc_idle), NUM_PROC);

  assign proc_ready_seen = rdy_seen;

  assign progress = (|rdy_ev) | (|proc_done) | (ap_idle & ~ap_start);
  assign st_clr   = stall_clr & (state == STALL);

  // Ready/done join bits; a clear wins over a same-cycle set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_seen  <= '0;
      done_seen <= '0;
    end else begin
      if (ap_ready | st_clr)
        rdy_seen <= '0;
      else
        rdy_seen <= rdy_seen | rdy_ev;
      if (ap_done | st_clr)
        done_seen <= '0;
      else
        done_seen <= done_seen | proc_done;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: run on start, leave on a clean done or a stall.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ap_start) state_nxt = RUN;
      end
      RUN: begin
        if (trip)
          state_nxt = STALL;
        else if (ap_done & ~ap_start & ~(|rdy_seen))
          state_nxt = IDLE;
      end
      STALL: begin
        if (stall_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  dataflow_watchdog #(
    .NUM_PROC    (NUM_PROC),
    .WD_W        (WD_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_wd (
    .clock        (clock),
    .reset        (reset),
    .run          (state == RUN),
    .hold         (state == IDLE),
    .clr          (st_clr),
    .stall_clr    (stall_clr),
    .progress     (progress),
    .rdy_seen     (rdy_seen),
    .rdy_ev       (rdy_ev),
    .trip         (trip),
    .stall_flag   (stall_flag),
    .stall_origin (stall_origin)
  );

endmodule

// File: tb/tb_dataflow_start_ctrl.sv
// Self-checking bench for dataflow_start_ctrl.
// Expected per-cycle outputs are queued at drive time, popped at sample.
module tb_dataflow_start_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       ap_start;
  logic       ap_ready;
  logic       ap_done;
  logic       ap_idle;
  logic [1:0] proc_start;
  logic [1:0] proc_ready;
  logic [1:0] proc_done;
  logic [1:0] proc_idle;
  logic [1:0] proc_ready_seen;
  logic       stall_clr;
  logic       stall_flag;
  logic [1:0] stall_origin;

  int    n_chk  = 0;
  int    n_fail = 0;
  string sc     = "reset";

  typedef struct packed {
    logic [1:0] start;
    logic       rdy;
    logic       done;
    logic [1:0] seen;
    logic       flag;
    logic [1:0] org;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  dataflow_start_ctrl #(
    .NUM_PROC    (2),
    .WD_W        (16),
    .STALL_LIMIT (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ap_start        (ap_start),
    .ap_ready        (ap_ready),
    .ap_done         (ap_done),
    .ap_idle         (ap_idle),
    .proc_start      (proc_start),
    .proc_ready      (proc_ready),
    .proc_done       (proc_done),
    .proc_idle       (proc_idle),
    .proc_ready_seen (proc_ready_seen),
    .stall_clr       (stall_clr),
    .stall_flag      (stall_flag),
    .stall_origin    (stall_origin)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", sc, tag, got, exp);
    end
  endtask

  int cyc_n = 0;

  task automatic cyc(input logic st, input logic [1:0] rd,
                     input logic [1:0] dn, input logic cl,
                     input logic [1:0] es, input logic er,
                     input logic ed, input logic [1:0] ev,
                     input logic ef, input logic [1:0] eo);
    exp_t e;
    string t;
    ap_start   = st;
    proc_ready = rd;
    proc_done  = dn;
    stall_clr  = cl;
    e = '{start: es, rdy: er, done: ed, seen: ev, flag: ef, org: eo};
    exp_q.push_back(e);
    @(negedge clock);
    e = exp_q.pop_front();
    t = $sformatf("c%0d", cyc_n);
    chk({t, ".start"}, 8'(proc_start), 8'(e.start));
    chk({t, ".ready"}, 8'(ap_ready), 8'(e.rdy));
    chk({t, ".done"}, 8'(ap_done), 8'(e.done));
    chk({t, ".seen"}, 8'(proc_ready_seen), 8'(e.seen));
    chk({t, ".flag"}, 8'(stall_flag), 8'(e.flag));
    chk({t, ".origin"}, 8'(stall_origin), 8'(e.org));
    cyc_n++;
    @(posedge clock);
    #1;
  endtask

  task automatic begin_sc(input string name);
    sc    = name;
    cyc_n = 0;
  endtask

  initial begin
    reset      = 1'b1;
    ap_start   = 1'b0;
    proc_ready = 2'b00;
    proc_done  = 2'b11;
    proc_idle  = 2'b11;
    stall_clr  = 1'b0;
    #7;
    chk("ap_ready", 8'(ap_ready), 8'd0);
    chk("ap_done", 8'(ap_done), 8'd0);
    chk("ap_idle", 8'(ap_idle), 8'd1);
    chk("seen", 8'(proc_ready_seen), 8'd0);
    chk("flag", 8'(stall_flag), 8'd0);
    chk("origin", 8'(stall_origin), 8'd0);
    proc_idle = 2'b01;
    #1;
    chk("ap_idle_part", 8'(ap_idle), 8'd0);
    proc_idle = 2'b00;
    proc_done = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    //  st rd    dn    cl es    er ed ev    ef eo
    begin_sc("balanced");
    cyc(1, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b11, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00);

    begin_sc("overlap");
    cyc(0, 2'b00, 2'b10, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b10, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b01, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);

    begin_sc("skew");
    cyc(1, 2'b01, 2'b00, 0, 2'b11, 0, 0, 2'b00, 0, 2'b00);
    cyc(1, 2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b01, 0, 2'b00);
    cyc(1, 2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b01, 0, 2'b00);
    cyc(1, 2'b10, 2'b00, 0, 2'b10, 1, 0, 2'b01, 0, 2'b00);
    cyc(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b10, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    for (int i = 0; i < 3; i++)
      cyc(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b01, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b01, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b10, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b10, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b01, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00);

    begin_sc("clr_prio");
    cyc(1, 2'b01, 2'b00, 0, 2'b11, 0, 0, 2'b00, 0, 2'b00);
    cyc(1, 2'b10, 2'b00, 0, 2'b10, 1, 0, 2'b01, 0, 2'b00);
    cyc(1, 2'b00, 2'b00, 0, 2'b11, 0, 0, 2'b00, 0, 2'b00);
    cyc(1, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b11, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00);

    begin_sc("stall");
    cyc(1, 2'b01, 2'b00, 0, 2'b11, 0, 0, 2'b00, 0, 2'b00);
    for (int i = 0; i < 8; i++)
      cyc(1, 2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b01, 0, 2'b00);
    cyc(1, 2'b10, 2'b00, 0, 2'b00, 0, 0, 2'b01, 1, 2'b10);
    cyc(1, 2'b00, 2'b00, 1, 2'b00, 0, 0, 2'b01, 1, 2'b10);
    cyc(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0, 2'b00);
    cyc(1, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b11, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00);

    begin_sc("mid_reset");
    cyc(1, 2'b01, 2'b00, 0, 2'b11, 0, 0, 2'b00, 0, 2'b00);
    for (int i = 0; i < 5; i++)
      cyc(1, 2'b00, 2'b00, 0, 2'b10, 0, 0, 2'b01, 0, 2'b00);
    #2;
    reset = 1'b1;
    #1;
    chk("rst.seen", 8'(proc_ready_seen), 8'd0);
    chk("rst.start", 8'(proc_start), 8'd3);
    chk("rst.flag", 8'(stall_flag), 8'd0);
    proc_ready = 2'b11;
    proc_done  = 2'b11;
    #1;
    chk("rst.ready", 8'(ap_ready), 8'd0);
    chk("rst.done", 8'(ap_done), 8'd0);
    @(negedge clock);
    proc_ready = 2'b00;
    proc_done  = 2'b00;
    reset      = 1'b0;
    @(posedge clock);
    #1;
    cyc(1, 2'b00, 2'b00, 0, 2'b11, 0, 0, 2'b00, 0, 2'b00);
    cyc(1, 2'b11, 2'b00, 0, 2'b11, 1, 0, 2'b00, 0, 2'b00);
    cyc(0, 2'b00, 2'b11, 0, 2'b00, 0, 1, 2'b00, 0, 2'b00);

    sc = "end";
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
